// File: rtl/prog_timer.sv
// prog_timer: programmable interval timer.
// A prescaler divides the clock by (prescale+1) while enabled; each prescaler
// wrap is a tick that advances a main up-counter from 0 to final_value.
// Reaching final_value on a tick is the terminal tick: the counter returns
// to 0, done pulses for one cycle and the sticky irq flag sets. One-shot mode
// drops back to IDLE on the terminal tick; periodic mode keeps running.
// mode, prescale and final_value are sampled only in an accepted start cycle.
module prog_timer #(
    parameter int BITS     = 16,
    parameter int PRE_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic                enable,
    input  logic                mode,
    input  logic [PRE_BITS-1:0] prescale,
    input  logic [BITS-1:0]     final_value,
    input  logic                irq_clr,
    output logic [BITS-1:0]     count,
    output logic                running,
    output logic                done,
    output logic                irq
);

    // Controller states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Increment constants sized to each counter
    localparam logic [BITS-1:0]     CNT_ONE  = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [PRE_BITS-1:0] PRE_ONE  = {{(PRE_BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0]     CNT_ZERO = {BITS{1'b0}};
    localparam logic [PRE_BITS-1:0] PRE_ZERO = {PRE_BITS{1'b0}};

    // Registers
    logic [0:0]          state_r;
    logic                running_r;
    logic [PRE_BITS-1:0] pre_cnt_r;
    logic [BITS-1:0]     count_r;
    logic                mode_lat_r;
    logic [PRE_BITS-1:0] prescale_lat_r;
    logic [BITS-1:0]     final_lat_r;
    logic                done_r;
    logic                irq_r;

    // Combinational control
    logic                start_acc_s;   // start accepted (stop has priority)
    logic                advance_s;     // prescaler advances this cycle
    logic                pre_wrap_s;    // prescaler at its latched limit
    logic                tick_s;        // main counter tick
    logic                terminal_s;    // tick with count at final value
    logic [0:0]          state_next_s;
    logic [PRE_BITS-1:0] pre_cnt_next_s;
    logic [BITS-1:0]     count_next_s;

    // Decode start/stop priority, tick and terminal tick
    always_comb begin
        start_acc_s = start & ~stop;
        // The start cycle itself only clears counters; it never ticks.
        advance_s   = (state_r == ST_RUN) & enable & ~stop & ~start;
        pre_wrap_s  = (pre_cnt_r == prescale_lat_r);
        tick_s      = advance_s & pre_wrap_s;
        terminal_s  = tick_s & (count_r == final_lat_r);
    end

    // Next-state logic of the IDLE/RUN controller
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next_s = ST_IDLE;
                end else if (start_acc_s) begin
                    state_next_s = ST_RUN;
                end else if (terminal_s && !mode_lat_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next value of the prescaler: clear on start, wrap on tick, hold otherwise
    always_comb begin
        pre_cnt_next_s = pre_cnt_r;
        if (start_acc_s) begin
            pre_cnt_next_s = PRE_ZERO;
        end else if (advance_s) begin
            if (pre_wrap_s) begin
                pre_cnt_next_s = PRE_ZERO;
            end else begin
                pre_cnt_next_s = pre_cnt_r + PRE_ONE;
            end
        end else begin
            pre_cnt_next_s = pre_cnt_r;
        end
    end

    // Next value of the main counter; it never passes final, so no wrap
    always_comb begin
        count_next_s = count_r;
        if (start_acc_s) begin
            count_next_s = CNT_ZERO;
        end else if (terminal_s) begin
            count_next_s = CNT_ZERO;
        end else if (tick_s) begin
            count_next_s = count_r + CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Controller state and the registered running flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            running_r <= (state_next_s == ST_RUN);
        end
    end

    // Prescaler and main counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= PRE_ZERO;
            count_r   <= CNT_ZERO;
        end else begin
            pre_cnt_r <= pre_cnt_next_s;
            count_r   <= count_next_s;
        end
    end

    // Configuration captured only in an accepted start cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_lat_r     <= 1'b0;
            prescale_lat_r <= PRE_ZERO;
            final_lat_r    <= CNT_ZERO;
        end else if (start_acc_s) begin
            mode_lat_r     <= mode;
            prescale_lat_r <= prescale;
            final_lat_r    <= final_value;
        end
    end

    // One-cycle done pulse and sticky irq; setting wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            done_r <= terminal_s;
            if (terminal_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr) begin
                irq_r <= 1'b0;
            end
        end
    end

    assign count   = count_r;
    assign running = running_r;
    assign done    = done_r;
    assign irq     = irq_r;

endmodule
